codec_biterr_acc: RTL and testbench

Parametrised bit-error counter for the codec test and measurement path. Counts the ones in a `pDAT_W`-bit error vector (decoded XOR reference) through a fixed 3-stage pipeline. Mode 0 reports the count for every word. Mode 1 accumulates the count over a `isop`..`ieop` frame and reports one saturated total per frame. It sits after the per-lane XOR stage and feeds the BER statistics registers.

---
 rtl/codec_biterr_acc.sv | 166 ++++++++++++++++
 tb/tb_codec_biterr_acc.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_biterr_acc.sv
// rtl/codec_biterr_acc.sv - 3-stage pipelined bit-error popcount with per-word or per-frame saturating totals
module codec_biterr_acc #(
    parameter int pDAT_W = 36,
    parameter int pERR_W = 16,
    parameter int pMODE  = 1
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              iclkena,
    input  logic              ival,
    input  logic              isop,
    input  logic              ieop,
    input  logic [pDAT_W-1:0] ibiterr,
    output logic              oval,
    output logic              osop,
    output logic              oeop,
    output logic [pERR_W-1:0] oerr,
    output logic              osat,
    output logic              onosop
);

    localparam int WS = $clog2(pDAT_W + 1);
    localparam int NG = (pDAT_W + 5) / 6;
    localparam int PW = NG * 6;

    generate
        if (pDAT_W < 1 || pDAT_W > 256) begin : g_bad_dat_w
            $error("codec_biterr_acc: pDAT_W out of range 1..256");
        end
        if (pERR_W < WS) begin : g_bad_err_w
            $error("codec_biterr_acc: pERR_W narrower than clog2(pDAT_W+1)");
        end
    endgenerate

    // Stage 1: 6-bit group popcounts, last group zero-padded
    logic [PW-1:0] pad;
    logic [2:0]    grp_next [NG];
    logic [2:0]    s1_cnt   [NG];
    logic          s1_val, s1_sop, s1_eop;

    assign pad = PW'(ibiterr);

    always_comb begin
        for (int g = 0; g < NG; g++) begin
            grp_next[g] = '0;
            for (int b = 0; b < 6; b++) begin
                grp_next[g] = grp_next[g] + 3'(pad[g*6+b]);
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            s1_val <= 1'b0;
            s1_sop <= 1'b0;
            s1_eop <= 1'b0;
            for (int g = 0; g < NG; g++) s1_cnt[g] <= '0;
        end else if (iclkena) begin
            s1_val <= ival;
            s1_sop <= ival & isop;
            s1_eop <= ival & ieop;
            for (int g = 0; g < NG; g++) s1_cnt[g] <= grp_next[g];
        end
    end

    // Stage 2: word sum
    logic [WS-1:0] word_next;
    logic [WS-1:0] s2_sum;
    logic          s2_val, s2_sop, s2_eop;

    always_comb begin
        word_next = '0;
        for (int g = 0; g < NG; g++) word_next = word_next + WS'(s1_cnt[g]);
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            s2_val <= 1'b0;
            s2_sop <= 1'b0;
            s2_eop <= 1'b0;
            s2_sum <= '0;
        end else if (iclkena) begin
            s2_val <= s1_val;
            s2_sop <= s1_sop;
            s2_eop <= s1_eop;
            s2_sum <= word_next;
        end
    end

    // Stage 3
    generate
        if (pMODE == 0) begin : g_word
            always_ff @(posedge iclk) begin
                if (ireset) begin
                    oval   <= 1'b0;
                    osop   <= 1'b0;
                    oeop   <= 1'b0;
                    oerr   <= '0;
                    osat   <= 1'b0;
                    onosop <= 1'b0;
                end else if (iclkena) begin
                    oval   <= s2_val;
                    osop   <= s2_sop;
                    oeop   <= s2_eop;
                    oerr   <= pERR_W'(s2_sum);
                    osat   <= 1'b0;
                    onosop <= 1'b0;
                end
            end
        end else begin : g_frame
            logic [pERR_W-1:0] acc;
            logic              open, sat, nosop;
            logic [pERR_W-1:0] base;
            logic [pERR_W:0]   run_ext;
            logic [pERR_W-1:0] run;
            logic              ovf, sat_now, nosop_now;

            // A sop word always restarts from zero, discarding any open frame
            always_comb begin
                base      = s2_sop ? '0 : acc;
                run_ext   = {1'b0, base} + (pERR_W+1)'(s2_sum);
                ovf       = run_ext[pERR_W];
                run       = ovf ? '1 : run_ext[pERR_W-1:0];
                sat_now   = (s2_sop ? 1'b0 : sat) | ovf;
                nosop_now = s2_sop ? 1'b0 : (nosop | ~open);
            end

            always_ff @(posedge iclk) begin
                if (ireset) begin
                    acc    <= '0;
                    open   <= 1'b0;
                    sat    <= 1'b0;
                    nosop  <= 1'b0;
                    oval   <= 1'b0;
                    osop   <= 1'b0;
                    oeop   <= 1'b0;
                    oerr   <= '0;
                    osat   <= 1'b0;
                    onosop <= 1'b0;
                end else if (iclkena) begin
                    oval <= 1'b0;
                    if (s2_val) begin
                        if (s2_eop) begin
                            oval   <= 1'b1;
                            osop   <= 1'b1;
                            oeop   <= 1'b1;
                            oerr   <= run;
                            osat   <= sat_now;
                            onosop <= nosop_now;
                            acc    <= '0;
                            open   <= 1'b0;
                            sat    <= 1'b0;
                            nosop  <= 1'b0;
                        end else begin
                            acc   <= run;
                            open  <= open | s2_sop;
                            sat   <= sat_now;
                            nosop <= nosop_now;
                        end
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_codec_biterr_acc.sv
// tb/tb_codec_biterr_acc.sv - directed self-checking bench for codec_biterr_acc
module tb_codec_biterr_acc;

    localparam logic [35:0] ALL = 36'hF_FFFF_FFFF;

    logic         iclk = 1'b0;
    logic         iclkena, ireset, ival, isop, ieop;
    logic [35:0]  d36;
    logic [0:0]   d1;
    logic [255:0] d256;

    logic        m0_oval, m0_osop, m0_oeop, m0_osat, m0_onosop;
    logic [15:0] m0_oerr;
    logic        m1_oval, m1_osop, m1_oeop, m1_osat, m1_onosop;
    logic [15:0] m1_oerr;
    logic        s8_oval, s8_osop, s8_oeop, s8_osat, s8_onosop;
    logic [7:0]  s8_oerr;
    logic        w1_oval, w1_osop, w1_oeop, w1_osat, w1_onosop;
    logic [3:0]  w1_oerr;
    logic        w2_oval, w2_osop, w2_oeop, w2_osat, w2_onosop;
    logic [8:0]  w2_oerr;

    int checks = 0;
    int errors = 0;

    always #5 iclk = ~iclk;

    codec_biterr_acc #(.pDAT_W(36), .pERR_W(16), .pMODE(0)) u_m0 (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival), .isop(isop), .ieop(ieop),
        .ibiterr(d36), .oval(m0_oval), .osop(m0_osop), .oeop(m0_oeop), .oerr(m0_oerr),
        .osat(m0_osat), .onosop(m0_onosop));

    codec_biterr_acc #(.pDAT_W(36), .pERR_W(16), .pMODE(1)) u_m1 (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival), .isop(isop), .ieop(ieop),
        .ibiterr(d36), .oval(m1_oval), .osop(m1_osop), .oeop(m1_oeop), .oerr(m1_oerr),
        .osat(m1_osat), .onosop(m1_onosop));

    codec_biterr_acc #(.pDAT_W(36), .pERR_W(8), .pMODE(1)) u_s8 (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival), .isop(isop), .ieop(ieop),
        .ibiterr(d36), .oval(s8_oval), .osop(s8_osop), .oeop(s8_oeop), .oerr(s8_oerr),
        .osat(s8_osat), .onosop(s8_onosop));

    codec_biterr_acc #(.pDAT_W(1), .pERR_W(4), .pMODE(1)) u_w1 (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival), .isop(isop), .ieop(ieop),
        .ibiterr(d1), .oval(w1_oval), .osop(w1_osop), .oeop(w1_oeop), .oerr(w1_oerr),
        .osat(w1_osat), .onosop(w1_onosop));

    codec_biterr_acc #(.pDAT_W(256), .pERR_W(9), .pMODE(0)) u_w2 (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival), .isop(isop), .ieop(ieop),
        .ibiterr(d256), .oval(w2_oval), .osop(w2_osop), .oeop(w2_oeop), .oerr(w2_oerr),
        .osat(w2_osat), .onosop(w2_onosop));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge iclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic e, input logic [35:0] d);
        ival = v;
        isop = s;
        ieop = e;
        d36  = d;
    endtask

    task automatic do_reset;
        drive(1'b0, 1'b0, 1'b0, '0);
        d1     = '0;
        d256   = '0;
        ireset = 1'b1;
        tick();
        ireset = 1'b0;
    endtask

    initial begin
        logic seen;
        iclkena = 1'b1;
        ireset  = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
        d1   = '0;
        d256 = '0;
        tick();
        tick();
        ireset = 1'b0;

        chk("rst_m0_oval", m0_oval, 0);
        chk("rst_m1_oval", m1_oval, 0);
        chk("rst_m1_oerr", m1_oerr, 0);
        chk("rst_m1_osat", m1_osat, 0);
        chk("rst_m1_onosop", m1_onosop, 0);

        // Mode 0 latency and counts; 256-bit instance rides along on the first word
        drive(1'b1, 1'b0, 1'b0, 36'h0);
        d256 = '1;
        tick();
        d256 = '0;
        drive(1'b1, 1'b0, 1'b0, ALL);
        tick();
        drive(1'b1, 1'b0, 1'b0, 36'h1);
        tick();
        chk("m0_w0_oval", m0_oval, 1);
        chk("m0_w0_oerr", m0_oerr, 0);
        chk("w256_oerr", w2_oerr, 256);
        chk("w256_oval", w2_oval, 1);
        drive(1'b0, 1'b0, 1'b0, '0);
        tick();
        chk("m0_w1_oval", m0_oval, 1);
        chk("m0_w1_oerr", m0_oerr, 36);
        tick();
        chk("m0_w2_oval", m0_oval, 1);
        chk("m0_w2_oerr", m0_oerr, 1);
        tick();
        chk("m0_idle_oval", m0_oval, 0);

        // Mode 1 frame with invalid gaps: 5 + 10 + 36
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 36'h1F);
        tick();
        drive(1'b0, 1'b0, 1'b0, ALL);
        tick();
        tick();
        drive(1'b1, 1'b0, 1'b0, 36'h3FF);
        tick();
        drive(1'b1, 1'b0, 1'b1, ALL);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0);
        tick();
        chk("gap_early_oval", m1_oval, 0);
        tick();
        chk("gap_oval", m1_oval, 1);
        chk("gap_oerr", m1_oerr, 51);
        chk("gap_osat", m1_osat, 0);
        chk("gap_onosop", m1_onosop, 0);
        chk("gap_osop", m1_osop, 1);
        chk("gap_oeop", m1_oeop, 1);
        tick();
        chk("gap_pulse_end", m1_oval, 0);
        chk("gap_oerr_hold", m1_oerr, 51);

        // Saturation: 8 x 36 = 288 errors into an 8-bit total
        do_reset();
        drive(1'b1, 1'b1, 1'b0, ALL);
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b0, ALL);
            tick();
        end
        drive(1'b1, 1'b0, 1'b1, ALL);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0);
        tick();
        tick();
        chk("sat_oval", s8_oval, 1);
        chk("sat_oerr", s8_oerr, 255);
        chk("sat_osat", s8_osat, 1);
        chk("sat_wide_oerr", m1_oerr, 288);
        chk("sat_wide_osat", m1_osat, 0);
        drive(1'b1, 1'b1, 1'b1, 36'h1);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0);
        tick();
        tick();
        chk("sat_next_oval", s8_oval, 1);
        chk("sat_next_oerr", s8_oerr, 1);
        chk("sat_next_osat", s8_osat, 0);

        // One-word frame, then back-to-back restarted frame 3 / 4 / 2
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 36'h7F);
        tick();
        drive(1'b1, 1'b1, 1'b0, 36'h7);
        tick();
        drive(1'b1, 1'b1, 1'b0, 36'hF);
        tick();
        chk("one_word_oval", m1_oval, 1);
        chk("one_word_oerr", m1_oerr, 7);
        chk("one_word_onosop", m1_onosop, 0);
        drive(1'b1, 1'b0, 1'b1, 36'h3);
        tick();
        chk("restart_gap_oval", m1_oval, 0);
        drive(1'b0, 1'b0, 1'b0, '0);
        tick();
        tick();
        chk("restart_oval", m1_oval, 1);
        chk("restart_oerr", m1_oerr, 6);

        // eop without any sop after reset
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 36'h1FF);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0);
        tick();
        tick();
        chk("nosop_oval", m1_oval, 1);
        chk("nosop_oerr", m1_oerr, 9);
        chk("nosop_flag", m1_onosop, 1);

        // Clock enable low for 4 cycles with valid words mid-frame
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 36'h1F);
        tick();
        iclkena = 1'b0;
        drive(1'b1, 1'b0, 1'b0, ALL);
        for (int i = 0; i < 4; i++) tick();
        iclkena = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 36'h3);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0);
        tick();
        tick();
        chk("ena_oval", m1_oval, 1);
        chk("ena_oerr", m1_oerr, 7);
        iclkena = 1'b0;
        tick();
        chk("ena_stretch", m1_oval, 1);
        iclkena = 1'b1;
        tick();
        chk("ena_pulse_end", m1_oval, 0);

        // Reset mid-frame drops the frame in flight
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 36'hFF);
        tick();
        drive(1'b1, 1'b0, 1'b0, 36'hF);
        tick();
        drive(1'b1, 1'b0, 1'b1, 36'h1);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0);
        ireset = 1'b1;
        tick();
        ireset = 1'b0;
        chk("midrst_oval", m1_oval, 0);
        chk("midrst_oerr", m1_oerr, 0);
        chk("midrst_osop", m1_osop, 0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (m1_oval !== 1'b0) seen = 1'b1;
        end
        chk("midrst_no_oval", seen, 0);
        drive(1'b1, 1'b1, 1'b0, 36'hFF);
        tick();
        drive(1'b1, 1'b0, 1'b1, 36'hF);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0);
        tick();
        tick();
        chk("after_rst_oval", m1_oval, 1);
        chk("after_rst_oerr", m1_oerr, 12);

        // 1-bit datapath, 3-word frame of ones
        do_reset();
        d1 = 1'b1;
        drive(1'b1, 1'b1, 1'b0, '0);
        tick();
        drive(1'b1, 1'b0, 1'b0, '0);
        tick();
        drive(1'b1, 1'b0, 1'b1, '0);
        tick();
        d1 = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0);
        tick();
        tick();
        chk("w1_oval", w1_oval, 1);
        chk("w1_oerr", w1_oerr, 3);
        chk("w1_onosop", w1_onosop, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
